// File: rtl/ddr3_pkg.sv
// Shared defaults and the command record carried through the DDR3 front-end queue.
package ddr3_pkg;

    localparam int DDR3_FIFO_DEPTH = 4;
    localparam int DDR3_MAX_READS  = 8;

    typedef struct packed {
        logic        is_write;
        logic [24:0] word_addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ddr3_cmd_t;

endpackage

// File: rtl/ddr3_interface_sync_fifo.sv
// Synchronous FIFO with occupancy count; head entry is visible on pop_data whenever not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr3_interface.sv
// Front-end between the memory mapper and an Avalon-style DDR3 controller:
// queued commands, read credit tracking and registered in-order read responses.
module ddr3_interface
    import ddr3_pkg::*;
#(
    parameter int FIFO_DEPTH = DDR3_FIFO_DEPTH,
    parameter int MAX_READS  = DDR3_MAX_READS
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ready,
    input  logic [26:0] addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        write_req,
    input  logic        read_req,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    input  logic        avl_ready,
    output logic [24:0] avl_addr,
    output logic [31:0] avl_wdata,
    output logic [3:0]  avl_be,
    output logic        avl_write_req,
    output logic        avl_read_req,
    input  logic [31:0] avl_rdata,
    input  logic        avl_rdata_valid,
    output logic        rd_underflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = $clog2(MAX_READS + 1);

    ddr3_cmd_t     push_cmd;
    ddr3_cmd_t     head_cmd;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          accept;
    logic          read_accept;
    logic          pop;
    logic          read_pop;
    logic [RW-1:0] queued_reads;
    logic [RW-1:0] outstanding;
    logic [RW:0]   reads_pending;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^addr[1:0];

    // Credits come only from registered counters, so ready never depends on avl_ready.
    assign reads_pending = {1'b0, queued_reads} + {1'b0, outstanding};
    assign ready         = (fifo_count < CW'(FIFO_DEPTH)) &
                           (reads_pending < (RW + 1)'(MAX_READS));
    assign accept        = (write_req | read_req) & ready;
    assign read_accept   = accept & ~write_req;

    always_comb begin
        push_cmd           = '0;
        push_cmd.is_write  = write_req;
        push_cmd.word_addr = addr[26:2];
        push_cmd.wdata     = write_data;
        push_cmd.be        = byte_enable;
    end

    sync_fifo #(
        .WIDTH ($bits(ddr3_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign avl_write_req = ~fifo_empty & head_cmd.is_write;
    assign avl_read_req  = ~fifo_empty & ~head_cmd.is_write;
    assign avl_addr      = head_cmd.word_addr;
    assign avl_wdata     = head_cmd.wdata;
    assign avl_be        = head_cmd.be;
    assign pop           = avl_ready & ~fifo_empty;
    assign read_pop      = pop & ~head_cmd.is_write;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            queued_reads <= '0;
            outstanding  <= '0;
            rd_underflow <= 1'b0;
        end else begin
            case ({read_accept, read_pop})
                2'b10:   queued_reads <= queued_reads + 1'b1;
                2'b01:   queued_reads <= queued_reads - 1'b1;
                default: ;
            endcase
            // A response with nothing in flight is still forwarded but flagged.
            if (read_pop && !avl_rdata_valid) begin
                outstanding <= outstanding + 1'b1;
            end else if (!read_pop && avl_rdata_valid) begin
                if (outstanding != '0) outstanding <= outstanding - 1'b1;
                else                   rd_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_data       <= '0;
            read_data_valid <= 1'b0;
        end else begin
            read_data_valid <= avl_rdata_valid;
            if (avl_rdata_valid) read_data <= avl_rdata;
        end
    end

endmodule

// File: tb/tb_ddr3_interface.sv
// Bench for ddr3_interface: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_ddr3_interface;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ready;
    logic [26:0] addr;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        write_req;
    logic        read_req;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        avl_ready;
    logic [24:0] avl_addr;
    logic [31:0] avl_wdata;
    logic [3:0]  avl_be;
    logic        avl_write_req;
    logic        avl_read_req;
    logic [31:0] avl_rdata;
    logic        avl_rdata_valid;
    logic        rd_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr3_interface dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ready           (ready),
        .addr            (addr),
        .write_data      (write_data),
        .byte_enable     (byte_enable),
        .write_req       (write_req),
        .read_req        (read_req),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .avl_ready       (avl_ready),
        .avl_addr        (avl_addr),
        .avl_wdata       (avl_wdata),
        .avl_be          (avl_be),
        .avl_write_req   (avl_write_req),
        .avl_read_req    (avl_read_req),
        .avl_rdata       (avl_rdata),
        .avl_rdata_valid (avl_rdata_valid),
        .rd_underflow    (rd_underflow)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [26:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        ar;
        logic        rv;
        logic [31:0] rdata;
        logic        e_ready;
        logic        e_awr;
        logic        e_ard;
        logic [24:0] e_aaddr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_rdv;
        logic [31:0] e_rdata;
        logic        e_uf;
    } vec_t;

    typedef struct {
        logic        is_write;
        logic [24:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mcmd_t;

    vec_t        vecs [12];
    mcmd_t       mq [$];
    mcmd_t       popped;
    int          m_out;
    logic        m_uf;
    logic        m_rdv;
    logic [31:0] m_rd;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [26:0] a,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input logic ar, input logic rv, input logic [31:0] rdt);
        write_req       = wr;
        read_req        = rd;
        addr            = a;
        write_data      = wd;
        byte_enable     = be;
        avl_ready       = ar;
        avl_rdata_valid = rv;
        avl_rdata       = rdt;
    endtask

    task automatic idle(input logic ar);
        applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0, ar, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        idle(1'b0);
        tick();
        reset_n = 1'b1;
    endtask

    task automatic clearModel();
        mq.delete();
        m_out = 0;
        m_uf  = 1'b0;
        m_rdv = 1'b0;
        m_rd  = 32'h0;
    endtask

    function automatic int queuedReads();
        int n = 0;
        foreach (mq[k]) if (!mq[k].is_write) n++;
        return n;
    endfunction

    initial begin
        logic        r_wr, r_rd, r_ar, r_rv, e_ready;
        logic [26:0] r_addr;
        logic [31:0] r_wd, r_rdt;
        logic [3:0]  r_be;

        reset_n = 1'b0;
        idle(1'b0);

        vecs[0]  = '{1'b1, 1'b0, 27'h104, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b1, 1'b0, 25'h41, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 27'h10, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b1, 25'h4, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h12345678,
                     1'b1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0, 1'b1, 32'h12345678, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 27'h203, 32'hA5A5A5A5, 4'h3, 1'b0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                     1'b1, 1'b1, 1'b0, 25'h80, 32'hA5A5A5A5, 4'h3, 1'b0, 32'h12345678, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b1, 1'b0, 25'h80, 32'hA5A5A5A5, 4'h3, 1'b0, 32'h12345678, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b0};

        tick();
        doReset();

        // Directed vector table: single write, single read, write+read collision.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                          vecs[i].ar, vecs[i].rv, vecs[i].rdata);
            checkOutput($sformatf("vec%0d ready", i), ready, vecs[i].e_ready);
            checkOutput($sformatf("vec%0d avl_write_req", i), avl_write_req, vecs[i].e_awr);
            checkOutput($sformatf("vec%0d avl_read_req", i), avl_read_req, vecs[i].e_ard);
            if (vecs[i].e_awr || vecs[i].e_ard)
                checkOutput($sformatf("vec%0d avl_addr", i), avl_addr, vecs[i].e_aaddr);
            if (vecs[i].e_awr) begin
                checkOutput($sformatf("vec%0d avl_wdata", i), avl_wdata, vecs[i].e_wdata);
                checkOutput($sformatf("vec%0d avl_be", i), avl_be, vecs[i].e_be);
            end
            checkOutput($sformatf("vec%0d read_data_valid", i), read_data_valid, vecs[i].e_rdv);
            checkOutput($sformatf("vec%0d read_data", i), read_data, vecs[i].e_rdata);
            checkOutput($sformatf("vec%0d rd_underflow", i), rd_underflow, vecs[i].e_uf);
            tick();
        end

        // Fill the queue with the controller stalled, then drain it in order.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 27'(32'h1000 + i * 4), 32'hF0000000 + i, 4'hF,
                          1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("fill%0d ready", i), ready, (i < 4));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            checkOutput($sformatf("drain%0d ready", i), ready, (i >= 1));
            checkOutput($sformatf("drain%0d avl_write_req", i), avl_write_req, 1'b1);
            checkOutput($sformatf("drain%0d avl_addr", i), avl_addr, 32'h400 + i);
            checkOutput($sformatf("drain%0d avl_wdata", i), avl_wdata, 32'hF0000000 + i);
            tick();
        end
        idle(1'b1);
        checkOutput("drained avl_write_req", avl_write_req, 1'b0);
        checkOutput("drained ready", ready, 1'b1);
        tick();

        // Read credit limit: eight reads with no responses, then one response.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 27'(i * 4), 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
            checkOutput($sformatf("credit%0d ready", i), ready, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 27'h100, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("credit exhausted ready", ready, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0BAD0001);
        checkOutput("credit response ready", ready, 1'b0);
        tick();
        idle(1'b1);
        checkOutput("credit returned ready", ready, 1'b1);
        checkOutput("credit read_data_valid", read_data_valid, 1'b1);
        checkOutput("credit read_data", read_data, 32'h0BAD0001);
        tick();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0BAD0002 + i);
            tick();
        end
        idle(1'b1);
        checkOutput("credit drained rd_underflow", rd_underflow, 1'b0);
        checkOutput("credit drained read_data", read_data, 32'h0BAD0008);
        tick();

        // Response with nothing outstanding: forwarded and flagged until reset.
        doReset();
        applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFEF00D);
        checkOutput("underflow pre flag", rd_underflow, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            checkOutput($sformatf("underflow%0d flag", i), rd_underflow, 1'b1);
            checkOutput($sformatf("underflow%0d read_data", i), read_data, 32'hCAFEF00D);
            checkOutput($sformatf("underflow%0d read_data_valid", i), read_data_valid, (i == 0));
            tick();
        end
        doReset();
        checkOutput("underflow cleared", rd_underflow, 1'b0);
        checkOutput("reset read_data", read_data, 32'h0);

        // Reset mid-operation discards queued commands.
        for (int i = 0; i < 3; i++) begin
            applyStimulus((i != 1), (i == 1), 27'(32'h40 + i * 4), 32'h11110000 + i, 4'hF,
                          1'b0, 1'b0, 32'h0);
            tick();
        end
        idle(1'b0);
        checkOutput("queued avl_write_req", avl_write_req, 1'b1);
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h77777777);
        tick();
        reset_n = 1'b1;
        idle(1'b1);
        checkOutput("midreset avl_write_req", avl_write_req, 1'b0);
        checkOutput("midreset avl_read_req", avl_read_req, 1'b0);
        checkOutput("midreset ready", ready, 1'b1);
        checkOutput("midreset read_data_valid", read_data_valid, 1'b0);
        checkOutput("midreset read_data", read_data, 32'h0);
        tick();
        idle(1'b1);
        checkOutput("midreset+1 avl_write_req", avl_write_req, 1'b0);
        checkOutput("midreset+1 avl_read_req", avl_read_req, 1'b0);
        tick();

        // Randomized traffic against the queue model, with occasional resets.
        doReset();
        clearModel();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 700 == 699) begin
                doReset();
                clearModel();
                continue;
            end
            r_wr   = ($urandom_range(0, 2) == 0);
            r_rd   = ($urandom_range(0, 2) == 0);
            r_addr = 27'($urandom);
            r_wd   = $urandom;
            r_be   = 4'($urandom);
            r_ar   = ($urandom_range(0, 3) != 0);
            r_rv   = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            r_rdt  = $urandom;
            applyStimulus(r_wr, r_rd, r_addr, r_wd, r_be, r_ar, r_rv, r_rdt);

            e_ready = (mq.size() < 4) && ((queuedReads() + m_out) < 8);
            checkOutput("rand ready", ready, e_ready);
            checkOutput("rand avl_write_req", avl_write_req, (mq.size() > 0) && mq[0].is_write);
            checkOutput("rand avl_read_req", avl_read_req, (mq.size() > 0) && !mq[0].is_write);
            if (mq.size() > 0) begin
                checkOutput("rand avl_addr", avl_addr, mq[0].waddr);
                if (mq[0].is_write) begin
                    checkOutput("rand avl_wdata", avl_wdata, mq[0].wdata);
                    checkOutput("rand avl_be", avl_be, mq[0].be);
                end
            end
            checkOutput("rand read_data_valid", read_data_valid, m_rdv);
            checkOutput("rand read_data", read_data, m_rd);
            checkOutput("rand rd_underflow", rd_underflow, m_uf);

            if (r_ar && mq.size() > 0) begin
                popped = mq.pop_front();
                if (!popped.is_write) m_out++;
            end
            if ((r_wr || r_rd) && e_ready)
                mq.push_back('{r_wr, r_addr[26:2], r_wd, r_be});
            if (r_rv) begin
                if (m_out > 0) m_out--;
                else           m_uf = 1'b1;
                m_rd = r_rdt;
            end
            m_rdv = r_rv;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
